seq_det_sched: RTL and testbench



---
 rtl/seq_det_sched.sv | 208 ++++++++++++++++++++
 tb/tb_seq_det_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_sched.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_sched
//  Purpose  : Round-robin scheduler that time-shares one external serial
//             Moore sequence detector among N requesters. For each granted
//             request the W-bit word is latched, the detector is cleared
//             through its async active-low reset, the word is shifted in
//             MSB-first, and the number of detector-high samples is
//             returned with a one-cycle done pulse.
//  Options  : SEQ_DET_FIXED_PRIO_EN - when defined, arbitration is fixed
//             priority (lowest index wins) and the round-robin pointer is
//             not consulted.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_det_sched #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   data,
    output logic [N-1:0]     gnt,
    output logic             done,
    output logic [CW-1:0]    result,
    output logic             det_x,
    output logic             det_nrst,
    input  logic             det_y
);

    localparam int            PW         = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] C_LAST_BIT = CW'(W - 1);
    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [PW-1:0] C_PTR_RST  = PW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q,    state_d;
    logic [N-1:0]    gnt_q,      gnt_d;
    logic [PW-1:0]   ptr_q,      ptr_d;
    logic [W-1:0]    shreg_q,    shreg_d;
    logic [CW-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [CW-1:0]   count_q,    count_d;
    logic [CW-1:0]   result_q,   result_d;
    logic            done_q,     done_d;
    logic            det_nrst_q, det_nrst_d;

    // Arbitration result: any request present and the winning index.
    logic            w_any;
    logic [PW-1:0]   w_win;

`ifdef SEQ_DET_FIXED_PRIO_EN
    // Fixed priority: scan high to low so the lowest requesting index is
    // the last (and therefore winning) assignment.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_any = 1'b1;
                w_win = PW'(i);
            end
        end
    end
`else
    logic [PW-1:0]   w_scan;

    // Round-robin: candidates are ptr+1, ptr+2, ... (mod N). Scanning the
    // offsets from farthest to nearest lets the nearest requester win.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_scan = '0;
        for (int k = N; k >= 1; k--) begin
            w_scan = PW'((int'(ptr_q) + k) % N);
            if (req[w_scan]) begin
                w_any = 1'b1;
                w_win = w_scan;
            end
        end
    end
`endif

    // State register and datapath flops; everything returns to idle
    // immediately on nrst, including mid-job.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            ptr_q      <= C_PTR_RST;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            count_q    <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            det_nrst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            count_q    <= count_d;
            result_q   <= result_d;
            done_q     <= done_d;
            det_nrst_q <= det_nrst_d;
        end
    end

    // Next-state and datapath updates for the job sequence
    // IDLE -> CLEAR -> SHIFT (W cycles) -> DRAIN -> DONE -> IDLE.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        count_d    = count_q;
        result_d   = result_q;
        done_d     = 1'b0;
        det_nrst_d = det_nrst_q;

        unique case (state_q)
            S_IDLE: begin
                // Detector is released while waiting; a grant pulls its
                // reset low for the following CLEAR cycle.
                det_nrst_d = 1'b1;
                if (w_any) begin
                    shreg_d        = data[w_win*W +: W];
                    gnt_d          = '0;
                    gnt_d[w_win]   = 1'b1;
                    ptr_d          = w_win;
                    count_d        = '0;
                    bit_cnt_d      = '0;
                    det_nrst_d     = 1'b0;
                    state_d        = S_CLEAR;
                end
            end

            S_CLEAR: begin
                det_nrst_d = 1'b1;
                bit_cnt_d  = '0;
                state_d    = S_SHIFT;
            end

            S_SHIFT: begin
                shreg_d = shreg_q << 1;
                // In the first SHIFT cycle det_y still shows the cleared
                // detector, not a response to any of our bits.
                if ((bit_cnt_q != '0) && det_y) begin
                    count_d = count_q + C_ONE;
                end
                if (bit_cnt_q == C_LAST_BIT) begin
                    bit_cnt_d = '0;
                    state_d   = S_DRAIN;
                end else begin
                    bit_cnt_d = bit_cnt_q + C_ONE;
                end
            end

            S_DRAIN: begin
                // Response to the last shifted bit; publish the final count
                // so it is valid together with done in the DONE cycle.
                if (det_y) begin
                    count_d  = count_q + C_ONE;
                    result_d = count_q + C_ONE;
                end else begin
                    result_d = count_q;
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end

            S_DONE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign result   = result_q;
    assign det_nrst = det_nrst_q;
    // Serial bit is only meaningful while shifting; held low otherwise.
    assign det_x    = (state_q == S_SHIFT) ? shreg_q[W-1] : 1'b0;

`ifndef SYNTHESIS
    a_gnt_onehot : assert property (@(posedge clk) disable iff (!nrst)
                                    $onehot0(gnt_q));
    a_done_gnt   : assert property (@(posedge clk) disable iff (!nrst)
                                    done_q |-> (gnt_q != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_det_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_det_sched
//  Purpose  : Self-checking bench for seq_det_sched. Hosts a serial Moore
//             detector (output high once "11" followed by one or more 0s has
//             been seen) and checks grants, serial stream, latency, and
//             results against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_det_sched;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic            clk = 1'b0;
    logic            nrst;
    logic [N-1:0]    req;
    logic [N*W-1:0]  data;
    logic [N-1:0]    gnt;
    logic            done;
    logic [CW-1:0]   result;
    logic            det_x;
    logic            det_nrst;
    logic            det_y;

    int checks = 0;
    int errors = 0;
    int ptr_m;

    seq_det_sched #(.N(N), .W(W)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .req      (req),
        .data     (data),
        .gnt      (gnt),
        .done     (done),
        .result   (result),
        .det_x    (det_x),
        .det_nrst (det_nrst),
        .det_y    (det_y)
    );

    always #5 clk = ~clk;

    // External detector: 0 idle, 1 saw "1", 2 saw "11", 3 saw "11" then 0s.
    logic [1:0] det_s;
    always_ff @(posedge clk or negedge det_nrst) begin
        if (!det_nrst) det_s <= 2'd0;
        else begin
            case (det_s)
                2'd0:    det_s <= det_x ? 2'd1 : 2'd0;
                2'd1:    det_s <= det_x ? 2'd2 : 2'd0;
                2'd2:    det_s <= det_x ? 2'd2 : 2'd3;
                default: det_s <= det_x ? 2'd1 : 2'd3;
            endcase
        end
    end
    assign det_y = (det_s == 2'd3);

    // Expected count: for every prefix of the word (MSB first), the
    // detector is high when the prefix ends in 1,1 followed by >=1 zeros.
    function automatic int model_count(input logic [W-1:0] w);
        int c = 0;
        for (int p = 1; p <= W; p++) begin
            int z = 0;
            while (z < p && w[W-p+z] == 1'b0) z++;
            if (z >= 1 && p >= z + 2 && w[W-p+z] == 1'b1 && w[W-p+z+1] == 1'b1)
                c++;
        end
        return c;
    endfunction

    function automatic int model_pick(input logic [N-1:0] rq);
`ifdef SEQ_DET_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (rq[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (rq[(ptr_m + k) % N]) return (ptr_m + k) % N;
`endif
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        req  = '0;
        repeat (2) @(negedge clk);
        nrst  = 1'b1;
        ptr_m = N - 1;
    endtask

    // Drive one job from a negedge and record what the DUT did.
    task automatic run_job(input logic [N-1:0] rq, input logic [N*W-1:0] dat,
                           input logic [N-1:0] rq_mid, input bit keep,
                           output logic [N-1:0] g, output logic [N-1:0] g_done,
                           output logic [W-1:0] xs, output int lat, output int nrst_low,
                           output logic [CW-1:0] res, output bit got,
                           output logic done_after, output int g_wait);
        int cyc;
        bit started;
        g = '0; g_done = '0; xs = '0; lat = 0; nrst_low = 0; res = '0;
        got = 1'b0; done_after = 1'b0; g_wait = -1; started = 1'b0; cyc = 0;
        req = rq; data = dat;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (!started && gnt != '0) begin started = 1'b1; g = gnt; g_wait = t; end
            if (started) begin
                cyc++;
                if (det_nrst === 1'b0) nrst_low++;
                if (cyc >= 2 && cyc <= W + 1) xs[W+1-cyc] = det_x;
                if (cyc == 3) req = rq_mid;
                if (done === 1'b1) begin
                    got = 1'b1; lat = cyc; res = result; g_done = gnt;
                    if (!keep) req = '0;
                end
            end
        end
        if (got) begin
            @(negedge clk);
            done_after = done;
        end else begin
            req = '0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (gnt !== '0)      begin errors++; $display("FAIL rst_gnt: got %b want 0", gnt); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (result !== '0)   begin errors++; $display("FAIL rst_result: got %0d want 0", result); end
        checks++; if (det_x !== 1'b0)  begin errors++; $display("FAIL rst_det_x: got %b want 0", det_x); end
        checks++; if (det_nrst !== 1'b0) begin errors++; $display("FAIL rst_det_nrst: got %b want 0", det_nrst); end
        nrst = 1'b1;
        ptr_m = N - 1;
        #1;
        checks++; if (det_nrst !== 1'b0) begin errors++; $display("FAIL rel_det_nrst_pre: got %b want 0", det_nrst); end
        @(negedge clk);
        checks++; if (det_nrst !== 1'b1) begin errors++; $display("FAIL rel_det_nrst_post: got %b want 1", det_nrst); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (gnt !== '0 || done !== 1'b0 || det_x !== 1'b0) begin
                errors++; $display("FAIL idle_quiet %0d: gnt=%b done=%b det_x=%b want 0/0/0", i, gnt, done, det_x);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0]  words [4] = '{8'hD0, 8'hC0, 8'hFF, 8'h00};
        int            want  [4] = '{1, 6, 0, 0};
        logic [N-1:0]  g, gd; logic [W-1:0] xs; logic [CW-1:0] res;
        int lat, nl, gw; bit got; logic da;
        for (int j = 0; j < 4; j++) begin
            run_job(4'b0001, {{(N-1)*W{1'b0}}, words[j]}, 4'b0001, 1'b0,
                    g, gd, xs, lat, nl, res, got, da, gw);
            ptr_m = 0;
            checks++; if (!got)         begin errors++; $display("FAIL dir_done %0d: no done within bound", j); end
            checks++; if (g !== 4'b0001) begin errors++; $display("FAIL dir_gnt %0d: got %b want 0001", j, g); end
            checks++; if (xs !== words[j]) begin errors++; $display("FAIL dir_det_x %0d: got %b want %b", j, xs, words[j]); end
            checks++; if (nl != 1)       begin errors++; $display("FAIL dir_nrst_low %0d: got %0d cycles want 1", j, nl); end
            checks++; if (lat != W + 3)  begin errors++; $display("FAIL dir_latency %0d: got %0d want %0d", j, lat, W + 3); end
            checks++; if (res !== CW'(want[j])) begin errors++; $display("FAIL dir_result %0d: got %0d want %0d", j, res, want[j]); end
            checks++; if (da !== 1'b0)   begin errors++; $display("FAIL dir_done_pulse %0d: done still %b", j, da); end
            repeat (3) @(negedge clk);
            checks++; if (result !== CW'(want[j])) begin errors++; $display("FAIL dir_hold %0d: got %0d want %0d", j, result, want[j]); end
        end
    endtask

    task automatic test_round_robin();
`ifdef SEQ_DET_FIXED_PRIO_EN
        logic [N-1:0] order [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        logic [N-1:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        logic [N-1:0] g, gd; logic [W-1:0] xs; logic [CW-1:0] res;
        int lat, nl, gw, w; bit got; logic da; logic [N*W-1:0] dat;
        do_reset();
        dat = {8'hC0, 8'hD0, 8'hFF, 8'hC0};
        for (int j = 0; j < 5; j++) begin
            w = model_pick(4'b1111);
            run_job(4'b1111, dat, 4'b1111, 1'b1, g, gd, xs, lat, nl, res, got, da, gw);
            ptr_m = w;
            checks++; if (g !== order[j]) begin errors++; $display("FAIL rr_gnt %0d: got %b want %b", j, g, order[j]); end
            checks++; if (gw != 0)        begin errors++; $display("FAIL rr_b2b_gap %0d: got %0d idle cycles want 0", j, gw); end
            checks++; if (res !== CW'(model_count(dat[w*W +: W]))) begin
                errors++; $display("FAIL rr_result %0d: got %0d want %0d", j, res, model_count(dat[w*W +: W])); end
        end
        req = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] g, gd, rq; logic [W-1:0] xs; logic [CW-1:0] res;
        int lat, nl, gw, w; bit got; logic da; logic [N*W-1:0] dat;
        for (int j = 0; j < 24; j++) begin
            rq = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) dat[i*W +: W] = W'($urandom);
            w = model_pick(rq);
            run_job(rq, dat, N'($urandom), 1'($urandom_range(0, 1)),
                    g, gd, xs, lat, nl, res, got, da, gw);
            ptr_m = w;
            checks++; if (g !== N'(1 << w)) begin errors++; $display("FAIL rnd_gnt %0d: got %b want %b (req %b)", j, g, N'(1 << w), rq); end
            checks++; if (xs !== dat[w*W +: W]) begin errors++; $display("FAIL rnd_det_x %0d: got %b want %b", j, xs, dat[w*W +: W]); end
            checks++; if (lat != W + 3 || nl != 1) begin errors++; $display("FAIL rnd_timing %0d: latency %0d nrst_low %0d want %0d/1", j, lat, nl, W + 3); end
            checks++; if (res !== CW'(model_count(dat[w*W +: W]))) begin
                errors++; $display("FAIL rnd_result %0d: got %0d want %0d", j, res, model_count(dat[w*W +: W])); end
        end
        req = '0;
    endtask

    task automatic test_mid_reset();
        logic [N-1:0] g, gd; logic [W-1:0] xs; logic [CW-1:0] res;
        int lat, nl, gw; bit got; logic da; bit seen;
        do_reset();
        run_job(4'b0001, {{(N-1)*W{1'b0}}, 8'hD0}, 4'b0001, 1'b0, g, gd, xs, lat, nl, res, got, da, gw);
        ptr_m = 0;
        checks++; if (res !== CW'(1)) begin errors++; $display("FAIL mr_pre_result: got %0d want 1", res); end
        req = 4'b0001; data = {{(N-1)*W{1'b0}}, 8'hC0};
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (gnt != '0) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL mr_grant: no grant within bound"); end
        repeat (2) @(negedge clk);
        checks++; if (det_x !== 1'b1) begin errors++; $display("FAIL mr_shift_x: got %b want 1", det_x); end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if (gnt !== '0 || done !== 1'b0 || result !== '0 || det_x !== 1'b0 || det_nrst !== 1'b0) begin
            errors++; $display("FAIL mr_async: gnt=%b done=%b result=%0d det_x=%b det_nrst=%b want all 0",
                               gnt, done, result, det_x, det_nrst);
        end
        req = '0;
        repeat (2) @(negedge clk);
        nrst = 1'b1; ptr_m = N - 1;
        run_job(4'b0001, {{(N-1)*W{1'b0}}, 8'hC0}, 4'b0001, 1'b0, g, gd, xs, lat, nl, res, got, da, gw);
        ptr_m = 0;
        checks++; if (res !== CW'(6) || g !== 4'b0001) begin errors++; $display("FAIL mr_post_job: result %0d gnt %b want 6/0001", res, g); end
    endtask

    task automatic test_drop();
        logic [N-1:0] g, gd, exp_g; logic [W-1:0] xs; logic [CW-1:0] res;
        int lat, nl, gw, w; bit got; logic da; logic [N*W-1:0] dat;
        do_reset();
        dat = {8'h00, 8'hD0, 8'hC0, 8'hFF};
        run_job(4'b0100, dat, 4'b0011, 1'b1, g, gd, xs, lat, nl, res, got, da, gw);
        ptr_m = 2;
        checks++; if (!got || g !== 4'b0100) begin errors++; $display("FAIL drop_grant: got=%0d gnt %b want 1/0100", got, g); end
        checks++; if (gd !== 4'b0100) begin errors++; $display("FAIL drop_gnt_at_done: got %b want 0100", gd); end
        checks++; if (res !== CW'(1)) begin errors++; $display("FAIL drop_result: got %0d want 1", res); end
        w = model_pick(4'b0011);
        exp_g = N'(1 << w);
        run_job(4'b0011, dat, 4'b0011, 1'b0, g, gd, xs, lat, nl, res, got, da, gw);
        ptr_m = w;
        checks++; if (g !== exp_g) begin errors++; $display("FAIL drop_next_gnt: got %b want %b", g, exp_g); end
        checks++; if (res !== CW'(model_count(dat[w*W +: W]))) begin
            errors++; $display("FAIL drop_next_result: got %0d want %0d", res, model_count(dat[w*W +: W])); end
    endtask

    initial begin
        nrst  = 1'b0;
        req   = '0;
        data  = '0;
        ptr_m = N - 1;
        test_reset();
        test_directed();
        test_round_robin();
        test_random();
        test_mid_reset();
        test_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
